// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe
//  Description : Registered RV32I/RV64I decode stage for OP-IMM, OP and LUI.
//                Reads the register file, optionally forwards same-cycle
//                writeback data, and holds the decoded result in an output
//                register behind a valid/ready handshake with flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ins,
    input  logic [ADDR_W-1:0] ins_addr2id,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_wen,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [3:0]        alu_op,
    output logic [4:0]        rd_addr,
    output logic              rd_wen,
    output logic [31:0]       ins2ex,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              illegal
);

    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_sll  = 4'd2;
    localparam logic [3:0] c_alu_slt  = 4'd3;
    localparam logic [3:0] c_alu_sltu = 4'd4;
    localparam logic [3:0] c_alu_xor  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_or   = 4'd8;
    localparam logic [3:0] c_alu_and  = 4'd9;

    // Shift amount width: 5 bits on RV32, 6 bits on RV64
    localparam int c_shw = (XLEN == 64) ? 6 : 5;

    // funct3 to ALU operation; alt selects the arithmetic right shift
    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = c_alu_add;
            3'b001:  r = c_alu_sll;
            3'b010:  r = c_alu_slt;
            3'b011:  r = c_alu_sltu;
            3'b100:  r = c_alu_xor;
            3'b101:  r = alt ? c_alu_sra : c_alu_srl;
            3'b110:  r = c_alu_or;
            default: r = c_alu_and;
        endcase
        return r;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [31:0]     w_lui_imm;
    logic            w_shift_hi_bad;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_dec_illegal;
    logic [3:0]      w_dec_alu;
    logic [XLEN-1:0] w_dec_op1;
    logic [XLEN-1:0] w_dec_op2;
    logic [4:0]      w_dec_rd;
    logic            w_dec_rd_wen;
    logic            w_accept;
    logic            w_load;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_wen_q, rd_wen_d;
    logic [31:0]       ins2ex_q, ins2ex_d;
    logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
    logic              illegal_q, illegal_d;

    assign w_opcode  = ins[6:0];
    assign w_funct3  = ins[14:12];
    assign w_funct7  = ins[31:25];
    assign w_lui_imm = {ins[31:12], 12'b0};

    // Only ins[30] may be set above the shamt field (and only for SRAI);
    // on RV32 bit 25 is not part of the shamt and must stay clear.
    assign w_shift_hi_bad = ins[31] || (|ins[29:26])
                         || ((w_funct3 == 3'b001) && ins[30])
                         || ((XLEN == 32) && ins[25]);

    assign rs1_addr = ((w_opcode == c_opc_op_imm) || (w_opcode == c_opc_op)) ? ins[19:15] : 5'd0;
    assign rs2_addr = (w_opcode == c_opc_op) ? ins[24:20] : 5'd0;

    assign w_rs1_hit = (BYPASS_EN != 0) && wb_wen && (wb_addr != 5'd0) && (wb_addr == rs1_addr);
    assign w_rs2_hit = (BYPASS_EN != 0) && wb_wen && (wb_addr != 5'd0) && (wb_addr == rs2_addr);

    // Operand fetch: x0 is hard zero, otherwise forward writeback on a hit
    always_comb begin
        w_rs1_val = w_rs1_hit ? wb_data : rs1_data;
        w_rs2_val = w_rs2_hit ? wb_data : rs2_data;
        if (rs1_addr == 5'd0) w_rs1_val = '0;
        if (rs2_addr == 5'd0) w_rs2_val = '0;
    end

    // Instruction decode; an illegal encoding collapses to an all-zero result
    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec_alu     = c_alu_add;
        w_dec_op1     = '0;
        w_dec_op2     = '0;
        case (w_opcode)
            c_opc_op_imm: begin
                w_dec_op1 = w_rs1_val;
                w_dec_op2 = {{(XLEN-12){ins[31]}}, ins[31:20]};
                w_dec_alu = f3_alu(w_funct3, ins[30]);
                if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                    w_dec_op2              = '0;
                    w_dec_op2[c_shw-1:0]   = ins[20 +: c_shw];
                    w_dec_illegal          = w_shift_hi_bad;
                end
            end
            c_opc_op: begin
                w_dec_op1 = w_rs1_val;
                w_dec_op2 = w_rs2_val;
                if (w_funct7 == 7'b0000000) begin
                    w_dec_alu = f3_alu(w_funct3, 1'b0);
                end else if ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)) begin
                    w_dec_alu = c_alu_sub;
                end else if ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b101)) begin
                    w_dec_alu = c_alu_sra;
                end else begin
                    w_dec_illegal = 1'b1;
                end
            end
            c_opc_lui: begin
                w_dec_op2 = XLEN'($signed(w_lui_imm));
            end
            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
        if (w_dec_illegal) begin
            w_dec_op1 = '0;
            w_dec_op2 = '0;
            w_dec_alu = c_alu_add;
        end
        w_dec_rd     = w_dec_illegal ? 5'd0 : ins[11:7];
        w_dec_rd_wen = !w_dec_illegal && (ins[11:7] != 5'd0);
    end

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && !flush;

    // Next-state for the output register: flush beats accept, drain on ready
    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_op_d    = alu_op_q;
        rd_addr_d   = rd_addr_q;
        rd_wen_d    = rd_wen_q;
        ins2ex_d    = ins2ex_q;
        ins_addr_d  = ins_addr_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (w_load) begin
            op1_d      = w_dec_op1;
            op2_d      = w_dec_op2;
            alu_op_d   = w_dec_alu;
            rd_addr_d  = w_dec_rd;
            rd_wen_d   = w_dec_rd_wen;
            ins2ex_d   = ins;
            ins_addr_d = ins_addr2id;
            illegal_d  = w_dec_illegal;
        end
    end

    // Output register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            rd_wen_q    <= 1'b0;
            ins2ex_q    <= '0;
            ins_addr_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_op_q    <= alu_op_d;
            rd_addr_q   <= rd_addr_d;
            rd_wen_q    <= rd_wen_d;
            ins2ex_q    <= ins2ex_d;
            ins_addr_q  <= ins_addr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign alu_op    = alu_op_q;
    assign rd_addr   = rd_addr_q;
    assign rd_wen    = rd_wen_q;
    assign ins2ex    = ins2ex_q;
    assign ins_addr  = ins_addr_q;
    assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage_pipe
//  Description : Self-checking bench for id_stage_pipe (bypass on and off).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready, wb_wen;
    logic [31:0] ins, ins_addr2id, rs1_data, rs2_data, wb_data;
    logic [4:0]  wb_addr;

    logic        in_ready, out_valid, rd_wen, illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] op1, op2, ins2ex, ins_addr;
    logic [3:0]  alu_op;

    logic        in_ready_n, out_valid_n, rd_wen_n, illegal_n;
    logic [4:0]  rs1_addr_n, rs2_addr_n, rd_addr_n;
    logic [31:0] op1_n, op2_n, ins2ex_n, ins_addr_n;
    logic [3:0]  alu_op_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .ADDR_W(32), .BYPASS_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .ins_addr2id(ins_addr2id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_wen(wb_wen), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op), .rd_addr(rd_addr), .rd_wen(rd_wen),
        .ins2ex(ins2ex), .ins_addr(ins_addr), .illegal(illegal)
    );

    id_stage_pipe #(.XLEN(32), .ADDR_W(32), .BYPASS_EN(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .ins(ins), .ins_addr2id(ins_addr2id), .rs1_addr(rs1_addr_n), .rs2_addr(rs2_addr_n),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_wen(wb_wen), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid_n), .out_ready(out_ready),
        .op1(op1_n), .op2(op2_n), .alu_op(alu_op_n), .rd_addr(rd_addr_n), .rd_wen(rd_wen_n),
        .ins2ex(ins2ex_n), .ins_addr(ins_addr_n), .illegal(illegal_n)
    );

    typedef struct {
        logic [4:0]  rs1a, rs2a;
        logic [31:0] op1, op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wen, ill;
    } dec_t;

    typedef struct {
        logic [31:0] ins, r1, r2;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] op1, op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rdw, ill;
        logic [31:0] op1n, op2n;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set rules
    function automatic dec_t model(input logic [31:0] i, input logic [31:0] r1d,
                                   input logic [31:0] r2d, input logic wen,
                                   input logic [4:0] wa, input logic [31:0] wd,
                                   input bit byp);
        dec_t d;
        int alu_of_f3[8];
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] v1, v2;
        bit legal;
        alu_of_f3 = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        d.rs1a = (opc == 7'h13 || opc == 7'h33) ? i[19:15] : 5'd0;
        d.rs2a = (opc == 7'h33) ? i[24:20] : 5'd0;
        v1 = (d.rs1a == 0) ? 32'd0 : ((byp && wen && wa == d.rs1a) ? wd : r1d);
        v2 = (d.rs2a == 0) ? 32'd0 : ((byp && wen && wa == d.rs2a) ? wd : r2d);
        legal = 0; d.op1 = 0; d.op2 = 0; d.alu = 0;
        if (opc == 7'h13) begin
            if (f3 == 1)      legal = (f7 == 0);
            else if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
            else              legal = 1;
            d.op1 = v1;
            d.op2 = (f3 == 1 || f3 == 5) ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
            d.alu = (f3 == 5 && i[30]) ? 4'd7 : 4'(alu_of_f3[f3]);
        end else if (opc == 7'h33) begin
            legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            d.op1 = v1;
            d.op2 = v2;
            d.alu = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : 4'(alu_of_f3[f3]);
        end else if (opc == 7'h37) begin
            legal = 1;
            d.op2 = {i[31:12], 12'h000};
        end
        if (!legal) begin
            d.op1 = 0; d.op2 = 0; d.alu = 0;
        end
        d.ill = !legal;
        d.rd  = legal ? i[11:7] : 5'd0;
        d.wen = legal && (i[11:7] != 0);
        return d;
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                         input logic v, input logic rdy, input logic fl);
        ins = i; rs1_data = r1; rs2_data = r2;
        in_valid = v; out_ready = rdy; flush = fl;
        wb_wen = 0; wb_addr = 0; wb_data = 0;
    endtask

    initial begin
        vec_t tbl[13];
        dec_t eb, en, mb, mn;
        logic ev;
        logic [31:0] eins, eaddr;

        //          ins           r1    r2   wen wa  wd      op1   op2           alu rd rdw ill op1n  op2n
        tbl[0]  = '{32'hFFD08293, 10,   0,   0,  0,  0,      10,   32'hFFFFFFFD, 0,  5, 1, 0,  10,   32'hFFFFFFFD};
        tbl[1]  = '{32'h402081B3, 20,   99,  1,  2,  7,      20,   7,            1,  3, 1, 0,  20,   99};
        tbl[2]  = '{32'h02109093, 5,    5,   0,  0,  0,      0,    0,            0,  0, 0, 1,  0,    0};
        tbl[3]  = '{32'h0000007F, 5,    5,   0,  0,  0,      0,    0,            0,  0, 0, 1,  0,    0};
        tbl[4]  = '{32'h00000013, 55,   0,   0,  0,  0,      0,    0,            0,  0, 0, 0,  0,    0};
        tbl[5]  = '{32'h123450B7, 3,    4,   0,  0,  0,      0,    32'h12345000, 0,  1, 1, 0,  0,    32'h12345000};
        tbl[6]  = '{32'h4041D113, 32'h80, 0, 0,  0,  0,      32'h80, 4,          7,  2, 1, 0,  32'h80, 4};
        tbl[7]  = '{32'hFFF2B213, 3,    0,   0,  0,  0,      3,    32'hFFFFFFFF, 4,  4, 1, 0,  3,    32'hFFFFFFFF};
        tbl[8]  = '{32'h0083F333, 32'hF0, 32'h3C, 0, 0, 0,   32'hF0, 32'h3C,     9,  6, 1, 0,  32'hF0, 32'h3C};
        tbl[9]  = '{32'h40839333, 1,    2,   0,  0,  0,      0,    0,            0,  0, 0, 1,  0,    0};
        tbl[10] = '{32'h000100B3, 11,   77,  1,  0,  5,      11,   0,            0,  1, 1, 0,  11,   0};
        tbl[11] = '{32'h0030D4B3, 32'h100, 2, 0, 0,  0,      32'h100, 2,         6,  9, 1, 0,  32'h100, 2};
        tbl[12] = '{32'h00F5C513, 1,    0,   1,  11, 32'hAA, 32'hAA, 32'hF,      5, 10, 1, 0,  1,    32'hF};

        // Reset state
        rst_n = 0; ins_addr2id = 0;
        drive(32'h0, 0, 0, 0, 1, 0);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_op1", op1, 0);
        chk("reset_ins2ex", ins2ex, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Table vectors, one accept per cycle
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].ins, tbl[k].r1, tbl[k].r2, 1, 1, 0);
            wb_wen = tbl[k].wen; wb_addr = tbl[k].wa; wb_data = tbl[k].wd;
            ins_addr2id = 32'h1000 + 32'(k * 4);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", k), out_valid, 1);
            chk($sformatf("tbl%0d_op1", k), op1, tbl[k].op1);
            chk($sformatf("tbl%0d_op2", k), op2, tbl[k].op2);
            chk($sformatf("tbl%0d_alu", k), alu_op, tbl[k].alu);
            chk($sformatf("tbl%0d_rd", k), rd_addr, tbl[k].rd);
            chk($sformatf("tbl%0d_rd_wen", k), rd_wen, tbl[k].rdw);
            chk($sformatf("tbl%0d_illegal", k), illegal, tbl[k].ill);
            chk($sformatf("tbl%0d_ins2ex", k), ins2ex, tbl[k].ins);
            chk($sformatf("tbl%0d_ins_addr", k), ins_addr, 32'h1000 + 32'(k * 4));
            chk($sformatf("tbl%0d_nb_op1", k), op1_n, tbl[k].op1n);
            chk($sformatf("tbl%0d_nb_op2", k), op2_n, tbl[k].op2n);
        end

        // Asynchronous reset in the middle of a cycle while a result is held
        drive(32'h0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_rd_wen", rd_wen, 0);
        chk("async_rst_op1", op1, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Backpressure: result held for 3 cycles, next accepted when ready returns
        drive(32'hFFD08293, 10, 0, 1, 1, 0);
        @(posedge clk); #1;
        chk("bp_first_valid", out_valid, 1);
        drive(32'h123450B7, 0, 0, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_op1", op1, 10);
            chk("bp_hold_op2", op2, 32'hFFFFFFFD);
            chk("bp_hold_rd", rd_addr, 5);
            chk("bp_hold_ins2ex", ins2ex, 32'hFFD08293);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_in_ready_back", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_op2", op2, 32'h12345000);
        chk("bp_next_rd", rd_addr, 1);
        chk("bp_next_ins2ex", ins2ex, 32'h123450B7);
        in_valid = 0;
        @(posedge clk); #1;
        chk("bp_drain_valid", out_valid, 0);

        // Flush with a same-cycle accept: nothing emerges
        drive(32'h123450B7, 0, 0, 1, 1, 1);
        @(posedge clk); #1;
        chk("flush_valid", out_valid, 0);
        drive(32'h0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("flush_no_late_result", out_valid, 0);
        end

        // Randomized traffic against the reference model
        ev = 0; eins = 0; eaddr = 0;
        eb = model(32'h0, 0, 0, 0, 0, 0, 1);
        en = eb;
        for (int n = 0; n < 600; n++) begin
            int kind;
            ins  = $urandom;
            kind = $urandom_range(0, 9);
            if (kind <= 3)      ins[6:0] = 7'h13;
            else if (kind <= 6) ins[6:0] = 7'h33;
            else if (kind == 7) ins[6:0] = 7'h37;
            else if (kind == 9) ins = 32'h00000013;
            if (ins[6:0] != 7'h37 && $urandom_range(0, 2) != 0)
                ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
            rs1_data    = $urandom;
            rs2_data    = $urandom;
            wb_wen      = ($urandom_range(0, 1) != 0);
            wb_data     = $urandom;
            kind        = $urandom_range(0, 3);
            wb_addr     = (kind == 0) ? ins[19:15] : ((kind == 1) ? ins[24:20] : 5'($urandom));
            ins_addr2id = $urandom;
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 15) == 0);

            @(negedge clk);
            mb = model(ins, rs1_data, rs2_data, wb_wen, wb_addr, wb_data, 1);
            mn = model(ins, rs1_data, rs2_data, wb_wen, wb_addr, wb_data, 0);
            chk("rnd_in_ready", in_ready, !ev || out_ready);
            chk("rnd_rs1_addr", rs1_addr, mb.rs1a);
            chk("rnd_rs2_addr", rs2_addr, mb.rs2a);
            if (flush) begin
                ev = 0;
            end else if (in_valid && (!ev || out_ready)) begin
                ev = 1; eb = mb; en = mn; eins = ins; eaddr = ins_addr2id;
            end else if (out_ready) begin
                ev = 0;
            end

            @(posedge clk); #1;
            chk("rnd_out_valid", out_valid, ev);
            chk("rnd_nb_out_valid", out_valid_n, ev);
            if (ev) begin
                chk("rnd_op1", op1, eb.op1);
                chk("rnd_op2", op2, eb.op2);
                chk("rnd_alu", alu_op, eb.alu);
                chk("rnd_rd", rd_addr, eb.rd);
                chk("rnd_rd_wen", rd_wen, eb.wen);
                chk("rnd_illegal", illegal, eb.ill);
                chk("rnd_ins2ex", ins2ex, eins);
                chk("rnd_ins_addr", ins_addr, eaddr);
                chk("rnd_nb_op1", op1_n, en.op1);
                chk("rnd_nb_op2", op2_n, en.op2);
                chk("rnd_nb_alu", alu_op_n, en.alu);
                chk("rnd_nb_illegal", illegal_n, en.ill);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
